// File: rtl/restador_serie_pkg.sv
// Shared constants for the bit-serial subtractor: FSM encoding, operand width, last-bit count.
package restador_serie_pkg;

  localparam int         DATA_W   = 8;
  localparam logic [2:0] LAST_BIT = 3'd7;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

endpackage

// File: rtl/restador_serie_if.sv
// Start/done handshake and operand/result bus between a test controller and restador_serie.
// RESTADOR_OVERFLOW_EN adds the registered signed-overflow flag ov.
interface restador_serie_if;
  import restador_serie_pkg::*;

  logic              start;
  logic [DATA_W-1:0] a;
  logic [DATA_W-1:0] b;
  logic              bi;
  logic              busy;
  logic              done;
  logic [DATA_W-1:0] d;
  logic              bo;
`ifdef RESTADOR_OVERFLOW_EN
  logic              ov;

  modport master (output start, a, b, bi, input busy, done, d, bo, ov);
  modport slave  (input start, a, b, bi, output busy, done, d, bo, ov);
`else
  modport master (output start, a, b, bi, input busy, done, d, bo);
  modport slave  (input start, a, b, bi, output busy, done, d, bo);
`endif

endinterface

// File: rtl/restador_serie_completo.sv
// Structural 1-bit full subtractor: d = x - y - bent, bsal is the borrow out.
module restador_completo #(parameter int PwrC = 0) (
  input  logic x,
  input  logic y,
  input  logic bent,
  output logic d,
  output logic bsal
);
  logic nx;
  logic t0;
  logic t1;
  logic t2;

  xor3_p #(.PwrC(PwrC)) u_diff (.a(x), .b(y), .c(bent), .y(d));

  // Borrow when x is 0 and something is taken from it, or both y and bent are set.
  inv_p  #(.PwrC(PwrC)) u_nx   (.a(x), .y(nx));
  and2_p #(.PwrC(PwrC)) u_t0   (.a(nx), .b(y), .y(t0));
  and2_p #(.PwrC(PwrC)) u_t1   (.a(nx), .b(bent), .y(t1));
  and2_p #(.PwrC(PwrC)) u_t2   (.a(y), .b(bent), .y(t2));
  or3_p  #(.PwrC(PwrC)) u_bsal (.a(t0), .b(t1), .c(t2), .y(bsal));
endmodule

// File: rtl/restador_serie_gates.sv
// Power-counting gate primitives; PwrC selects the power counter each instance reports to.
module inv_p #(parameter int PwrC = 0) (
  input  logic a,
  output logic y
);
  if (PwrC < 0) begin : g_bad_pwrc
    $error("inv_p: PwrC must be non-negative");
  end
  assign y = ~a;
endmodule

module and2_p #(parameter int PwrC = 0) (
  input  logic a,
  input  logic b,
  output logic y
);
  if (PwrC < 0) begin : g_bad_pwrc
    $error("and2_p: PwrC must be non-negative");
  end
  assign y = a & b;
endmodule

module or3_p #(parameter int PwrC = 0) (
  input  logic a,
  input  logic b,
  input  logic c,
  output logic y
);
  if (PwrC < 0) begin : g_bad_pwrc
    $error("or3_p: PwrC must be non-negative");
  end
  assign y = a | b | c;
endmodule

module xor3_p #(parameter int PwrC = 0) (
  input  logic a,
  input  logic b,
  input  logic c,
  output logic y
);
  if (PwrC < 0) begin : g_bad_pwrc
    $error("xor3_p: PwrC must be non-negative");
  end
  assign y = a ^ b ^ c;
endmodule

// File: rtl/restador_serie.sv
// Bit-serial 8-bit subtractor d = a - b - bi, LSB first, one bit per clock, start/done handshake.
// RESTADOR_OVERFLOW_EN adds the signed-overflow output ov on the bus.
module restador_serie
  import restador_serie_pkg::*;
#(
  parameter int PwrC  = 0,
  parameter int WIDTH = 8
) (
  input  logic              clk,
  input  logic              reset,
  restador_serie_if.slave   bus
);

  if (WIDTH != DATA_W) begin : g_width_chk
    $error("restador_serie: WIDTH must equal DATA_W");
  end

  state_t             state_reg;
  state_t             state_next;
  logic [WIDTH-1:0]   a_sh_reg;
  logic [WIDTH-1:0]   b_sh_reg;
  logic               br_reg;
  logic [2:0]         cnt_reg;
  logic [WIDTH-2:0]   res_reg;
  logic [WIDTH-1:0]   d_reg;
  logic               bo_reg;
`ifdef RESTADOR_OVERFLOW_EN
  logic               ov_reg;
`endif

  logic load;
  logic shift_en;
  logic last_bit;
  logic diff;
  logic nbr;

  restador_completo #(.PwrC(PwrC)) u_cell (
    .x    (a_sh_reg[0]),
    .y    (b_sh_reg[0]),
    .bent (br_reg),
    .d    (diff),
    .bsal (nbr)
  );

  always_ff @(posedge clk) begin
    if (reset) state_reg <= IDLE;
    else       state_reg <= state_next;
  end

  always_comb begin
    state_next = state_reg;
    case (state_reg)
      IDLE:    if (bus.start) state_next = RUN;
      RUN:     if (cnt_reg == LAST_BIT) state_next = DONE;
      DONE:    state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  always_comb begin
    load     = (state_reg == IDLE) && bus.start;
    shift_en = (state_reg == RUN);
    last_bit = (state_reg == RUN) && (cnt_reg == LAST_BIT);
  end

  // Result register keeps only the first seven bits; the eighth goes straight into d.
  always_ff @(posedge clk) begin
    if (reset) begin
      a_sh_reg <= '0;
      b_sh_reg <= '0;
      br_reg   <= 1'b0;
      cnt_reg  <= 3'd0;
      res_reg  <= '0;
      d_reg    <= '0;
      bo_reg   <= 1'b0;
`ifdef RESTADOR_OVERFLOW_EN
      ov_reg   <= 1'b0;
`endif
    end else if (load) begin
      a_sh_reg <= bus.a;
      b_sh_reg <= bus.b;
      br_reg   <= bus.bi;
      cnt_reg  <= 3'd0;
      res_reg  <= '0;
    end else if (shift_en) begin
      a_sh_reg <= a_sh_reg >> 1;
      b_sh_reg <= b_sh_reg >> 1;
      br_reg   <= nbr;
      cnt_reg  <= cnt_reg + 3'd1;
      res_reg  <= {diff, res_reg[WIDTH-2:1]};
      if (last_bit) begin
        d_reg  <= {diff, res_reg};
        bo_reg <= nbr;
`ifdef RESTADOR_OVERFLOW_EN
        // On the last bit the shift registers hold the captured operand MSBs.
        ov_reg <= (a_sh_reg[0] ^ b_sh_reg[0]) & (a_sh_reg[0] ^ diff);
`endif
      end
    end
  end

  assign bus.busy = (state_reg == RUN);
  assign bus.done = (state_reg == DONE);
  assign bus.d    = d_reg;
  assign bus.bo   = bo_reg;
`ifdef RESTADOR_OVERFLOW_EN
  assign bus.ov   = ov_reg;
`endif

endmodule

// File: tb/tb_restador_serie.sv
// Directed self-checking bench for restador_serie; RESTADOR_OVERFLOW_EN also exercises ov.
module tb_restador_serie;

  logic clk;
  logic reset;
  int   checks;
  int   failures;
  int   busy_cnt;
  int   done_cnt;
  int   done_at;

  restador_serie_if bus ();

  restador_serie #(.PwrC(0), .WIDTH(8)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp)
    else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Issues one start, optionally injects a second start at RUN cycle inj_cyc, and
  // watches 12 cycles after the accepting edge.
  task automatic run_op(input logic [7:0] av, input logic [7:0] bv, input logic biv,
                        input int inj_cyc, output int n_busy, output int n_done,
                        output int at_done);
    @(negedge clk);
    bus.a     = av;
    bus.b     = bv;
    bus.bi    = biv;
    bus.start = 1'b1;
    n_busy  = 0;
    n_done  = 0;
    at_done = 0;
    for (int i = 1; i <= 12; i++) begin
      @(negedge clk);
      if (bus.busy) n_busy++;
      if (bus.done) begin
        n_done++;
        at_done = i;
      end
      bus.start = (i == inj_cyc);
      if (i == inj_cyc) begin
        bus.a  = 8'hFF;
        bus.b  = 8'h00;
        bus.bi = 1'b1;
      end
    end
    $display("op a=%02h b=%02h bi=%0d -> d=%02h bo=%0d busy_cycles=%0d done_pulses=%0d done_cycle=%0d",
             av, bv, biv, bus.d, bus.bo, n_busy, n_done, at_done);
  endtask

  initial begin
    checks    = 0;
    failures  = 0;
    reset     = 1'b1;
    bus.start = 1'b0;
    bus.a     = 8'h00;
    bus.b     = 8'h00;
    bus.bi    = 1'b0;
    repeat (2) @(negedge clk);
    check("rst_busy", {31'd0, bus.busy}, 32'd0);
    check("rst_done", {31'd0, bus.done}, 32'd0);
    check("rst_d", {24'd0, bus.d}, 32'h00);
    check("rst_bo", {31'd0, bus.bo}, 32'd0);
`ifdef RESTADOR_OVERFLOW_EN
    check("rst_ov", {31'd0, bus.ov}, 32'd0);
`endif
    reset = 1'b0;

    run_op(8'h5A, 8'h3C, 1'b0, 0, busy_cnt, done_cnt, done_at);
    check("t1_busy_cycles", busy_cnt, 32'd8);
    check("t1_done_pulses", done_cnt, 32'd1);
    check("t1_done_cycle", done_at, 32'd9);
    check("t1_d", {24'd0, bus.d}, 32'h1E);
    check("t1_bo", {31'd0, bus.bo}, 32'd0);

    run_op(8'h00, 8'h01, 1'b0, 0, busy_cnt, done_cnt, done_at);
    check("t2_done_pulses", done_cnt, 32'd1);
    check("t2_d", {24'd0, bus.d}, 32'hFF);
    check("t2_bo", {31'd0, bus.bo}, 32'd1);

    run_op(8'h10, 8'h10, 1'b1, 0, busy_cnt, done_cnt, done_at);
    check("t3_d", {24'd0, bus.d}, 32'hFF);
    check("t3_bo", {31'd0, bus.bo}, 32'd1);
    done_cnt = 0;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      if (bus.done) done_cnt++;
    end
    $display("idle 5 cycles -> d=%02h done_pulses=%0d", bus.d, done_cnt);
    check("t3_idle_done", done_cnt, 32'd0);
    check("t3_idle_d_hold", {24'd0, bus.d}, 32'hFF);

    run_op(8'h20, 8'h05, 1'b0, 3, busy_cnt, done_cnt, done_at);
    check("t4_done_pulses", done_cnt, 32'd1);
    check("t4_busy_cycles", busy_cnt, 32'd8);
    check("t4_d", {24'd0, bus.d}, 32'h1B);
    check("t4_bo", {31'd0, bus.bo}, 32'd0);

    // Abort at the 4th RUN cycle; d must fall from 1B to the reset value.
    @(negedge clk);
    bus.a     = 8'h44;
    bus.b     = 8'h11;
    bus.bi    = 1'b0;
    bus.start = 1'b1;
    @(negedge clk);
    bus.start = 1'b0;
    repeat (3) @(negedge clk);
    check("t5_busy_before_rst", {31'd0, bus.busy}, 32'd1);
    reset = 1'b1;
    @(negedge clk);
    $display("reset mid-run -> busy=%0d done=%0d d=%02h bo=%0d", bus.busy, bus.done, bus.d, bus.bo);
    check("t5_busy", {31'd0, bus.busy}, 32'd0);
    check("t5_done", {31'd0, bus.done}, 32'd0);
    check("t5_d", {24'd0, bus.d}, 32'h00);
    check("t5_bo", {31'd0, bus.bo}, 32'd0);
    reset = 1'b0;
    done_cnt = 0;
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      if (bus.done) done_cnt++;
    end
    check("t5_no_done_after_abort", done_cnt, 32'd0);

    run_op(8'h03, 8'h01, 1'b0, 0, busy_cnt, done_cnt, done_at);
    check("t6_done_pulses", done_cnt, 32'd1);
    check("t6_d", {24'd0, bus.d}, 32'h02);
    check("t6_bo", {31'd0, bus.bo}, 32'd0);

`ifdef RESTADOR_OVERFLOW_EN
    run_op(8'h80, 8'h01, 1'b0, 0, busy_cnt, done_cnt, done_at);
    check("ov1_d", {24'd0, bus.d}, 32'h7F);
    check("ov1_bo", {31'd0, bus.bo}, 32'd0);
    check("ov1_ov", {31'd0, bus.ov}, 32'd1);
    run_op(8'h05, 8'h03, 1'b0, 0, busy_cnt, done_cnt, done_at);
    check("ov2_d", {24'd0, bus.d}, 32'h02);
    check("ov2_ov", {31'd0, bus.ov}, 32'd0);
`endif

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
